seq_divider: RTL and testbench

//  Sequential unsigned restoring divider, the inverse operation of the datapath's

---
 rtl/seq_divider_pkg.sv | 25 ++
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider_trial_subtractor.sv | 27 ++
 rtl/seq_divider.sv | 141 ++++++++++++++
 tb/tb_seq_divider.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: state encoding, counter sizing
// and the full-adder cell the trial subtractor is built from.
package seq_divider_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_e;

  // Counter must be able to hold WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for the divider: requester drives start and operands,
// the divider returns busy, the done pulse and held results.
interface seq_divider_if #(
  parameter int WIDTH = 3
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_trial_subtractor.sv
// Combinational ripple subtractor a-b (b inverted, carry-in 1); zero latency.
// no_borrow is the final carry, i.e. high when a >= b.
module trial_subtractor
  import seq_divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_fa
    logic [1:0] fa_out;
    assign fa_out     = full_add(a[i], ~b[i], carry[i]);
    assign diff[i]    = fa_out[0];
    assign carry[i+1] = fa_out[1];
  end

  assign no_borrow = carry[N];

endmodule

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock: done WIDTH+1 cycles after accept
// (1 cycle for divide-by-zero); start is only sampled in IDLE, otherwise dropped.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_sr_q, quo_sr_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   trial_diff;
  logic             trial_ok;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  // Top bit of R is shifted out every step; after a restore it is always zero.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[WIDTH];

  assign trial_a = {rem_q[WIDTH-1:0], quo_sr_q[WIDTH-1]};
  assign trial_b = {1'b0, divisor_q};

  trial_subtractor #(
    .N (WIDTH + 1)
  ) u_trial_sub (
    .a         (trial_a),
    .b         (trial_b),
    .diff      (trial_diff),
    .no_borrow (trial_ok)
  );

  assign rem_next = trial_ok ? trial_diff : trial_a;
  assign quo_next = {quo_sr_q[WIDTH-2:0], trial_ok};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_sr_d    = quo_sr_q;
    divisor_d   = divisor_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          divisor_d = bus.divisor;
          rem_d     = '0;
          quo_sr_d  = bus.dividend;
          cnt_d     = CW'(WIDTH);
          dbz_d     = 1'b0;
          if (bus.divisor == '0) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            dbz_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = bus.dividend;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end
      end

      ST_RUN: begin
        rem_d    = rem_next;
        quo_sr_d = quo_next;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = quo_next;
          remainder_d = rem_next[WIDTH-1:0];
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_sr_q    <= '0;
      divisor_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_sr_q    <= quo_sr_d;
      divisor_q   <= divisor_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed checks of the 3-bit sequential divider: reset, single ops, divide by
// zero, ignored start, mid-run reset, and all 64 operand pairs back to back.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(3)) bus ();

  seq_divider #(.WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] eq, input logic [2:0] er, input logic edbz,
                       input int elat, input int ebusy, input string nm);
    int   lat  = 0;
    int   bcnt = 0;
    logic seen = 1'b0;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    while (!seen && lat < 20) begin
      tick();
      bus.start = 1'b0;
      lat++;
      if (bus.busy === 1'b1) bcnt++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    total++;
    if (lat !== elat) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", nm, lat, elat);
    end
    total++;
    if (bcnt !== ebusy) begin
      bad++; $display("FAIL %s busy_cycles got=%0d want=%0d", nm, bcnt, ebusy);
    end
    total++;
    if (bus.quotient !== eq) begin
      bad++; $display("FAIL %s quotient got=%0d want=%0d", nm, bus.quotient, eq);
    end
    total++;
    if (bus.remainder !== er) begin
      bad++; $display("FAIL %s remainder got=%0d want=%0d", nm, bus.remainder, er);
    end
    total++;
    if (bus.div_by_zero !== edbz) begin
      bad++; $display("FAIL %s dbz got=%b want=%b", nm, bus.div_by_zero, edbz);
    end
    tick();
    total++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      bad++; $display("FAIL %s after_done {done,busy} got=%b want=00", nm, {bus.done, bus.busy});
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = 3'd0;
    bus.divisor  = 3'd0;
    #12;
    total++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 9'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0",
               {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero});
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL reset_release {busy,done} got=%b want=00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_basic();
    do_op(3'd6, 3'd2, 3'd3, 3'd0, 1'b0, 4, 3, "div_6_2");
    do_op(3'd7, 3'd3, 3'd2, 3'd1, 1'b0, 4, 3, "div_7_3");
    do_op(3'd2, 3'd5, 3'd0, 3'd2, 1'b0, 4, 3, "div_2_5");
    do_op(3'd7, 3'd1, 3'd7, 3'd0, 1'b0, 4, 3, "div_7_1");
  endtask

  task automatic test_div_zero();
    do_op(3'd5, 3'd0, 3'd7, 3'd5, 1'b1, 1, 0, "div_5_0");
    do_op(3'd4, 3'd3, 3'd1, 3'd1, 1'b0, 4, 3, "dbz_clears");
  endtask

  task automatic test_start_ignored();
    int   lat  = 0;
    logic seen = 1'b0;
    logic extra = 1'b0;
    bus.dividend = 3'd7;
    bus.divisor  = 3'd3;
    bus.start    = 1'b1;
    tick(); lat++;
    bus.start = 1'b0;
    tick(); lat++;
    bus.dividend = 3'd1;
    bus.divisor  = 3'd1;
    bus.start    = 1'b1;
    tick(); lat++;
    bus.start    = 1'b0;
    bus.dividend = 3'd0;
    bus.divisor  = 3'd0;
    if (bus.done === 1'b1) seen = 1'b1;
    while (!seen && lat < 20) begin
      tick(); lat++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL ignore_latency got=%0d want=4", lat);
    end
    total++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {3'd2, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL ignore_result q/r/dbz got=%0d/%0d/%b want=2/1/0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.busy === 1'b1 || bus.done === 1'b1) extra = 1'b1;
    end
    total++;
    if (extra !== 1'b0) begin
      bad++; $display("FAIL ignore_no_queued_op activity got=%b want=0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.dividend = 3'd7;
    bus.divisor  = 3'd3;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL midrst_busy_before got=%b want=1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 9'd0) begin
      bad++;
      $display("FAIL midrst_outputs got=%b want=0",
               {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero});
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL midrst_idle {busy,done} got=%b want=00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        int   lat  = 0;
        logic seen = 1'b0;
        int   eq, er, elat;
        logic edbz;
        bus.dividend = 3'(a);
        bus.divisor  = 3'(b);
        if (b == 0) begin
          eq = 7; er = a; edbz = 1'b1; elat = 1;
        end else begin
          eq = a / b; er = a % b; edbz = 1'b0; elat = 4;
        end
        while (!seen && lat < 20) begin
          tick(); lat++;
          if (bus.done === 1'b1) seen = 1'b1;
        end
        total++;
        if (lat !== elat) begin
          bad++; $display("FAIL b2b_latency %0d/%0d got=%0d want=%0d", a, b, lat, elat);
        end
        total++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {3'(eq), 3'(er), edbz}) begin
          bad++;
          $display("FAIL b2b_result %0d/%0d q/r/dbz got=%0d/%0d/%b want=%0d/%0d/%b",
                   a, b, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, edbz);
        end
        if (b != 0) begin
          total++;
          if ((int'(bus.quotient) * b + int'(bus.remainder) !== a) || (int'(bus.remainder) >= b)) begin
            bad++;
            $display("FAIL b2b_invariant %0d/%0d q=%0d r=%0d", a, b, bus.quotient, bus.remainder);
          end
        end
        tick();
        total++;
        if (bus.done !== 1'b0) begin
          bad++; $display("FAIL b2b_done_width %0d/%0d done got=%b want=0", a, b, bus.done);
        end
      end
    end
    bus.start = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
